// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the memory-port arbiter slice.
//   state_e   : arbiter ownership states (IDLE, OWN0, OWN1)
//   REQ_P/L   : requester ids (processor = 0, loader/debug = 1)
//   DEF_AW/DW : default address / data widths
//   tag_t     : read-return tag {valid, id} carried through the RAM latency
//   sat_inc16 : 16-bit saturating increment used by the optional statistics
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int DEF_AW = 6;
  localparam int DEF_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  localparam logic REQ_P = 1'b0;
  localparam logic REQ_L = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles both requester handshakes and the memory pins.
//   reqN/weN/addrN/wdataN : requester N access request (level, held until gntN)
//   gntN                  : requester N beat accepted this cycle
//   rvalidN/rdataN        : requester N read return
//   mem_addr/data/wren    : towards the synchronous RAM
//   mem_q                 : RAM read data, valid RD_LAT cycles after address
// Modports: slave = arbiter side, master = requesters + memory side.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int AW = 6,
  parameter int DW = 16
);

  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_wren;
  logic [DW-1:0] mem_q;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_q,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output mem_addr, mem_data, mem_wren
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_q,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  mem_addr, mem_data, mem_wren
  );

endinterface

// File: rtl/mem_port_arbiter_tag_pipe.sv
// -----------------------------------------------------------------------------
// mem_arb_tag_pipe
// RD_LAT-deep shift register of read tags, aligned with the RAM read latency:
// a tag pushed with the address pops out in the cycle mem_q carries its data.
//   i_clk / i_rst_n : clock, asynchronous active-low reset (clears all tags)
//   i_push          : tag entering this cycle (valid=0 for writes / no beat)
//   o_pop           : tag leaving the pipe this cycle
//   o_any_valid     : some read is still in flight
// -----------------------------------------------------------------------------
module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  tag_t i_push,
  output tag_t o_pop,
  output logic o_any_valid
);

  logic [RD_LAT-1:0] w_valid_vec;

  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
      tag_t r_tag;
      tag_t w_in;

      if (gi == 0) begin : g_head
        assign w_in = i_push;
      end else begin : g_body
        assign w_in = g_stage[gi-1].r_tag;
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_tag <= '0;
        else          r_tag <= w_in;
      end

      assign w_valid_vec[gi] = r_tag.valid;
    end
  endgenerate

  assign o_pop       = g_stage[RD_LAT-1].r_tag;
  assign o_any_valid = |w_valid_vec;

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one synchronous-RAM port between the processor (R0) and a
// loader/debug master (R1). Round-robin ownership with bounded bursts under
// contention; grants are combinational, including the handover cycle, so the
// port never idles while someone is asking. Read data is steered back to the
// issuing requester using a tag pipe matched to the RAM latency.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : requester handshakes + memory pins (mem_port_arbiter_if)
//   o_busy         : owner present or read in flight
// Optional (MEM_PORT_ARBITER_STATS_EN): o_gcnt0/o_gcnt1 granted beats per
// requester and o_wcnt cycles with a waiting requester, 16-bit saturating.
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  mem_port_arbiter_if.slave   bus,
  output logic                o_busy
`ifdef MEM_PORT_ARBITER_STATS_EN
  ,
  output logic [15:0]         o_gcnt0,
  output logic [15:0]         o_gcnt1,
  output logic [15:0]         o_wcnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_OWN0 = 2'(ST_OWN0);
  localparam logic [1:0] S_OWN1 = 2'(ST_OWN1);

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic       r_ptr;
  logic [3:0] r_cnt;

  logic       w_sel_valid;
  logic       w_sel_id;
  logic       w_cnt_full;
  logic       w_owner_valid;
  logic       w_owner_id;
  logic       w_continue;
  logic       w_leave;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_sel_we;

  tag_t       w_push;
  tag_t       w_pop;
  logic       w_tag_any;
  logic       w_ret0;
  logic       w_ret1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  assign w_cnt_full    = (r_cnt >= 4'(MAX_BURST));
  assign w_owner_valid = (r_state != S_IDLE);
  assign w_owner_id    = (r_state == S_OWN1);

  // Arbitration is evaluated every cycle from the registered owner; the
  // grant is gated by reset so nothing reaches the RAM while held in reset.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_id    = r_ptr;
    if (i_rst_n) begin
      case (r_state)
        S_IDLE: begin
          if (bus.req0 && bus.req1) begin
            w_sel_valid = 1'b1;
            w_sel_id    = r_ptr;
          end else if (bus.req0) begin
            w_sel_valid = 1'b1;
            w_sel_id    = REQ_P;
          end else if (bus.req1) begin
            w_sel_valid = 1'b1;
            w_sel_id    = REQ_L;
          end
        end
        S_OWN0: begin
          // Keep streaming unless the burst is spent and R1 is waiting.
          if (bus.req0 && !(w_cnt_full && bus.req1)) begin
            w_sel_valid = 1'b1;
            w_sel_id    = REQ_P;
          end else if (bus.req1) begin
            w_sel_valid = 1'b1;
            w_sel_id    = REQ_L;
          end
        end
        S_OWN1: begin
          if (bus.req1 && !(w_cnt_full && bus.req0)) begin
            w_sel_valid = 1'b1;
            w_sel_id    = REQ_L;
          end else if (bus.req0) begin
            w_sel_valid = 1'b1;
            w_sel_id    = REQ_P;
          end
        end
        default: begin
          w_sel_valid = 1'b0;
        end
      endcase
    end
  end

  assign w_continue   = w_owner_valid && w_sel_valid && (w_sel_id == w_owner_id);
  assign w_leave      = w_owner_valid && !w_continue;
  assign w_state_next = !w_sel_valid ? S_IDLE : (w_sel_id ? S_OWN1 : S_OWN0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= REQ_P;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      if (w_leave) r_ptr <= ~w_owner_id;
      // The granted beat of a new owner is already its first burst beat.
      if (w_continue)       r_cnt <= (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
      else if (w_sel_valid) r_cnt <= 4'd1;
      else                  r_cnt <= 4'd0;
    end
  end

  assign w_gnt0   = w_sel_valid && (w_sel_id == REQ_P);
  assign w_gnt1   = w_sel_valid && (w_sel_id == REQ_L);
  assign w_sel_we = w_sel_id ? bus.we1 : bus.we0;

  assign bus.gnt0     = w_gnt0;
  assign bus.gnt1     = w_gnt1;
  assign bus.mem_wren = w_sel_valid && w_sel_we;
  assign bus.mem_addr = !w_sel_valid ? '0 : (w_sel_id ? bus.addr1 : bus.addr0);
  assign bus.mem_data = !w_sel_valid ? '0 : (w_sel_id ? bus.wdata1 : bus.wdata0);

  assign w_push.valid = w_sel_valid && !w_sel_we;
  assign w_push.id    = w_sel_id;

  mem_arb_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (w_push),
    .o_pop       (w_pop),
    .o_any_valid (w_tag_any)
  );

  assign w_ret0 = w_pop.valid && (w_pop.id == REQ_P);
  assign w_ret1 = w_pop.valid && (w_pop.id == REQ_L);

  // rdata shows mem_q in the return cycle and then holds it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (w_ret0) r_rdata0 <= bus.mem_q;
      if (w_ret1) r_rdata1 <= bus.mem_q;
    end
  end

  assign bus.rvalid0 = w_ret0;
  assign bus.rvalid1 = w_ret1;
  assign bus.rdata0  = w_ret0 ? bus.mem_q : r_rdata0;
  assign bus.rdata1  = w_ret1 ? bus.mem_q : r_rdata1;

  assign o_busy = w_owner_valid || w_tag_any;

`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [15:0] r_gcnt0;
  logic [15:0] r_gcnt1;
  logic [15:0] r_wcnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gcnt0 <= '0;
      r_gcnt1 <= '0;
      r_wcnt  <= '0;
    end else begin
      if (w_gnt0) r_gcnt0 <= sat_inc16(r_gcnt0);
      if (w_gnt1) r_gcnt1 <= sat_inc16(r_gcnt1);
      if ((bus.req0 && !w_gnt0) || (bus.req1 && !w_gnt1)) r_wcnt <= sat_inc16(r_wcnt);
    end
  end

  assign o_gcnt0 = r_gcnt0;
  assign o_gcnt1 = r_gcnt1;
  assign o_wcnt  = r_wcnt;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed scenarios followed by random requester traffic. A behavioural
// model (ownership rules, a reference memory array and a queue of pending
// read returns) predicts every grant, memory beat, read return and busy.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW        = 6;
  localparam int DW        = 16;
  localparam int RD_LAT    = 1;
  localparam int MAX_BURST = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic load_mem = 1'b1;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus();

`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [15:0] gcnt0, gcnt1, wcnt;
`endif

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus),
    .o_busy  (busy)
`ifdef MEM_PORT_ARBITER_STATS_EN
    ,
    .o_gcnt0 (gcnt0),
    .o_gcnt1 (gcnt1),
    .o_wcnt  (wcnt)
`endif
  );

  // ---------------- synchronous RAM (read-first, RD_LAT cycles) ------------
  logic [DW-1:0] tb_mem [64];
  logic [DW-1:0] q_pipe [RD_LAT];

  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 5) return 16'hABCD;
    return DW'((a * 16'h0137) ^ 16'h5A5A);
  endfunction

  always @(posedge clk) begin
    if (load_mem) begin
      for (int k = 0; k < 64; k++) tb_mem[k] <= init_word(k);
    end else if (bus.mem_wren) begin
      tb_mem[bus.mem_addr] <= bus.mem_data;
    end
    q_pipe[0] <= tb_mem[bus.mem_addr];
    for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end

  assign bus.mem_q = q_pipe[RD_LAT-1];

  // ---------------- reference model ----------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } ret_t;

  logic [DW-1:0] ref_mem [64];
  ret_t          rq[$];
  int            m_owner = -1;
  int            m_beats = 0;
  int            m_ptr   = 0;
  logic [DW-1:0] last_rd [2];
  bit            last_g  [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Who should hold the port this cycle, from the ownership rules.
  function automatic int pick(input bit r0, input bit r1);
    bit r[2];
    r[0] = r0;
    r[1] = r1;
    if (m_owner < 0) begin
      if (r0 && r1) return m_ptr;
      if (r0) return 0;
      if (r1) return 1;
      return -1;
    end
    if (r[m_owner] && !(m_beats >= MAX_BURST && r[1-m_owner])) return m_owner;
    if (r[1-m_owner]) return 1 - m_owner;
    return -1;
  endfunction

  task automatic set_req(input int id, input bit r, input bit we, input int addr,
                         input logic [DW-1:0] d);
    if (id == 0) begin
      bus.req0 = r; bus.we0 = we; bus.addr0 = AW'(addr); bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = we; bus.addr1 = AW'(addr); bus.wdata1 = d;
    end
  endtask

  // Called 1 time unit after a rising edge with inputs already applied.
  task automatic step();
    int            sel;
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            rv [2];
    bit            exp_busy;
    ret_t          r;
    #4;
    sel = pick(bus.req0, bus.req1);
    we  = (sel == 1) ? bus.we1   : bus.we0;
    a   = (sel == 1) ? bus.addr1 : bus.addr0;
    d   = (sel == 1) ? bus.wdata1 : bus.wdata0;
    chk("gnt0", 32'(bus.gnt0), 32'(sel == 0));
    chk("gnt1", 32'(bus.gnt1), 32'(sel == 1));
    chk("mem_wren", 32'(bus.mem_wren), 32'(sel >= 0 && we));
    if (sel >= 0) begin
      chk("mem_addr", 32'(bus.mem_addr), 32'(a));
      if (we) chk("mem_data", 32'(bus.mem_data), 32'(d));
      $display("cyc %0d beat R%0d %s addr=%0d data=%h", cyc, sel, we ? "WR" : "RD", a, d);
    end
    rv[0] = 1'b0;
    rv[1] = 1'b0;
    exp_busy = (m_owner >= 0) || (rq.size() > 0);
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      rv[r.id] = 1'b1;
      last_rd[r.id] = r.data;
      $display("cyc %0d return R%0d data=%h", cyc, r.id, r.data);
    end
    chk("rvalid0", 32'(bus.rvalid0), 32'(rv[0]));
    chk("rvalid1", 32'(bus.rvalid1), 32'(rv[1]));
    chk("rdata0", 32'(bus.rdata0), 32'(last_rd[0]));
    chk("rdata1", 32'(bus.rdata1), 32'(last_rd[1]));
    chk("busy", 32'(busy), 32'(exp_busy));
    if (sel >= 0) begin
      if (we) begin
        ref_mem[a] = d;
      end else begin
        r.due = cyc + RD_LAT; r.id = sel; r.data = ref_mem[a];
        rq.push_back(r);
      end
    end
    if (m_owner >= 0 && sel != m_owner) m_ptr = 1 - m_owner;
    m_beats = (sel >= 0 && sel == m_owner) ? m_beats + 1 : ((sel >= 0) ? 1 : 0);
    m_owner = sel;
    last_g[0] = (sel == 0);
    last_g[1] = (sel == 1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outputs();
    chk("rst_gnt0", 32'(bus.gnt0), 0);
    chk("rst_gnt1", 32'(bus.gnt1), 0);
    chk("rst_rvalid0", 32'(bus.rvalid0), 0);
    chk("rst_rvalid1", 32'(bus.rvalid1), 0);
    chk("rst_rdata0", 32'(bus.rdata0), 0);
    chk("rst_rdata1", 32'(bus.rdata1), 0);
    chk("rst_wren", 32'(bus.mem_wren), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_data", 32'(bus.mem_data), 0);
    chk("rst_busy", 32'(busy), 0);
  endtask

  task automatic model_reset();
    rq.delete();
    m_owner = -1;
    m_beats = 0;
    m_ptr   = 0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    last_g[0]  = 1'b0;
    last_g[1]  = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 64; k++) ref_mem[k] = init_word(k);
    model_reset();
    set_req(0, 0, 0, 0, '0);
    set_req(1, 0, 0, 0, '0);
    repeat (2) @(posedge clk);
    #1;
    load_mem = 1'b0;
    // Reset state, with a request pending to show grants are suppressed.
    set_req(0, 1, 0, 7, '0);
    #1;
    check_reset_outputs();
    set_req(0, 0, 0, 0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single R0 read of address 5.
    set_req(0, 1, 0, 5, '0);
    step();
    set_req(0, 0, 0, 0, '0);
    repeat (RD_LAT + 1) step();
    chk("hold_rdata0_5", 32'(bus.rdata0), 32'h0000ABCD);

    // Both request from IDLE and are held: bursts of MAX_BURST alternate.
    set_req(0, 1, 0, 10, '0);
    set_req(1, 1, 0, 20, '0);
    for (int k = 0; k < 20; k++) begin
      step();
      if (last_g[0]) bus.addr0 = AW'($urandom);
      if (last_g[1]) bus.addr1 = AW'($urandom);
    end
    set_req(0, 0, 0, 0, '0);
    set_req(1, 0, 0, 0, '0);
    repeat (RD_LAT + 2) step();

    // Interleaved reads: R0 addr 1 then R1 addr 2 on consecutive cycles.
    set_req(0, 1, 0, 1, '0);
    step();
    set_req(0, 0, 0, 0, '0);
    set_req(1, 1, 0, 2, '0);
    step();
    set_req(1, 0, 0, 0, '0);
    repeat (RD_LAT + 2) step();

    // R1 writes 0x1234 to address 9, R0 reads it back.
    set_req(1, 1, 1, 9, 16'h1234);
    step();
    set_req(1, 0, 0, 0, '0);
    set_req(0, 1, 0, 9, '0);
    step();
    set_req(0, 0, 0, 0, '0);
    repeat (RD_LAT + 1) step();
    chk("readback9", 32'(bus.rdata0), 32'h00001234);

    // Reset one cycle after a granted read.
    set_req(0, 1, 0, 3, '0);
    step();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    set_req(0, 0, 0, 0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (RD_LAT + 3) step();

    // Random traffic: requests held until granted, then re-rolled.
    for (int k = 0; k < 300; k++) begin
      for (int id = 0; id < 2; id++) begin
        bit held;
        held = (id == 0) ? (bus.req0 && !last_g[0]) : (bus.req1 && !last_g[1]);
        if (!held) begin
          set_req(id, $urandom_range(0, 99) < 65, $urandom_range(0, 2) == 0,
                  int'($urandom_range(0, 63)), DW'($urandom));
        end
      end
      step();
    end
    set_req(0, 0, 0, 0, '0);
    set_req(1, 0, 0, 0, '0);
    repeat (RD_LAT + 2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
